// File: rtl/sram_host_pkg.sv
// Shared opcodes, frame size and FSM state encoding for the SPI SRAM host.
// Frame layout: opcode, {3'b000, addr}, data byte.
package sram_host_pkg;

    localparam int         FRAME_BITS = 32;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_e;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic        wr,
        input logic [12:0] addr,
        input logic [7:0]  wdata
    );
        build_frame = {wr ? OP_WRITE : OP_READ, 3'b000, addr,
                       wr ? wdata : 8'h00};
    endfunction

endpackage

// File: rtl/sram_spi_host_sck_gen.sv
// Serial clock divider: CLK_DIV clk cycles per sck half-period.
// rise/fall strobe in the cycle just before sck changes level.
module sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstb,
    input  logic en,
    input  logic freeze,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sck_q, sck_d;
    logic       tick;

    assign tick = en && !freeze && (cnt_q == LAST);
    assign rise = tick && !sck_q;
    assign fall = tick && sck_q;
    // Masking by en keeps sck low the moment the frame leaves SHIFT.
    assign sck  = sck_q && en;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (!freeze) begin
            if (tick) begin
                cnt_d = '0;
                sck_d = !sck_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/sram_spi_host.sv
// SPI mode-0 host for a serial SRAM: one byte READ/WRITE per request.
// Define SRAM_HOST_HOLD_EN to add the hold_req input driving holdb.
module sram_spi_host
    import sram_host_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        req,
    input  logic        wr,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        csb,
    output logic        sck,
    output logic        si,
    input  logic        so,
    output logic        holdb
`ifdef SRAM_HOST_HOLD_EN
    ,
    input  logic        hold_req
`endif
);

    localparam logic [7:0] GAP_LAST = 8'(CLK_DIV - 1);
    localparam logic [5:0] BITS_ALL = 6'(FRAME_BITS);
    localparam logic [5:0] RD_FIRST = 6'd24;

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   frame_q, frame_d;
    logic                    wr_q, wr_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;
    logic [7:0]              rx_q, rx_d;
    logic [7:0]              rdata_q, rdata_d;
    logic                    gen_en, freeze, rise, fall;

    assign gen_en = (state_q == SETUP) || (state_q == SHIFT);

`ifdef SRAM_HOST_HOLD_EN
    assign freeze = hold_req && (state_q == SHIFT) && !sck;
`else
    assign freeze = 1'b0;
`endif

    sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk   (clk),
        .rstb  (rstb),
        .en    (gen_en),
        .freeze(freeze),
        .sck   (sck),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        wr_d      = wr_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = SETUP;
                    wr_d      = wr;
                    frame_d   = build_frame(wr, addr, wdata);
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end
            end
            SETUP: begin
                if (rise) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 6'd1;
                end
            end
            SHIFT: begin
                // The rise after the 32nd pulse's low phase ends the frame.
                if (rise) begin
                    if (bit_cnt_q == BITS_ALL) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        if (!wr_q && bit_cnt_q >= RD_FIRST)
                            rx_d = {rx_q[6:0], so};
                    end
                end
                if (fall)
                    frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = DONE;
                    if (!wr_q)
                        rdata_d = rx_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            wr_q      <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            wr_q      <= wr_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign csb   = !gen_en;
    assign si    = frame_q[FRAME_BITS-1];
    assign holdb = !freeze;

endmodule

// File: tb/tb_sram_spi_host.sv
// Randomized bench for sram_spi_host with a behavioural serial SRAM.
// Define SRAM_HOST_HOLD_EN to also exercise the hold feature.
`timescale 1ns/1ps
module tb_sram_spi_host;

    localparam int D   = 2;
    localparam int LIM = 66 * D + 200;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        busy, done, csb, sck, si, holdb;
    logic        so = 1'b0;
`ifdef SRAM_HOST_HOLD_EN
    logic        hold_req = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_spi_host #(
        .CLK_DIV(D)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .req  (req),
        .wr   (wr),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .busy (busy),
        .done (done),
        .csb  (csb),
        .sck  (sck),
        .si   (si),
        .so   (so),
        .holdb(holdb)
`ifdef SRAM_HOST_HOLD_EN
        ,
        .hold_req(hold_req)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial SRAM model plus bus monitor, observed away from the clk edge.
    logic [7:0]  smem [8192];
    logic [7:0]  rmem [8192];
    logic [7:0]  ref_rdata = '0;
    logic [31:0] fr = '0;
    logic [7:0]  rbyte = '0;
    logic        sck_p = 1'b0;
    logic        csb_p = 1'b1;
    int          rises = 0;
    int          hi_len = 0;
    int          csb_hi = 0;
    int          last_gap = 0;
    int          width_err = 0;
    int          done_cnt = 0;
    logic [31:0] fq [$];
    int          rq [$];

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (csb === 1'b1) csb_hi++;
        if (csb === 1'b0 && csb_p) begin
            last_gap = csb_hi;
            csb_hi   = 0;
            rises    = 0;
            fr       = '0;
        end
        if (csb === 1'b1 && !csb_p) begin
            fq.push_back(fr);
            rq.push_back(rises);
            if (rises == 32 && fr[31:24] == 8'h02)
                smem[fr[20:8]] = fr[7:0];
        end
        if (sck === 1'b1) hi_len++;
        if (csb === 1'b0 && sck === 1'b1 && !sck_p) begin
            fr = {fr[30:0], si};
            rises++;
            if (rises == 24) rbyte = smem[fr[12:0]];
        end
        if (sck === 1'b0 && sck_p) begin
            if (csb === 1'b0 && hi_len != D) width_err++;
            hi_len = 0;
        end
        if (csb === 1'b0 && sck === 1'b0)
            so = (rises >= 24 && rises < 32) ? rbyte[31-rises]
                                              : 1'($urandom);
        sck_p = (sck === 1'b1);
        csb_p = (csb !== 1'b0);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int n = 0; n < LIM; n++) begin
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_txn(input logic w, input logic [12:0] a,
                           input logic [7:0] d, input bit dbl,
                           input bit hold);
        logic [31:0] exp_fr;
        logic [7:0]  exp_rd;
        int          lat;
        int          dc0;
        int          hcnt;
        bit          got;
        bit          hstart;
        exp_fr = {(w ? 8'h02 : 8'h03), 3'b000, a, (w ? d : 8'h00)};
        exp_rd = w ? ref_rdata : rmem[a];
        if (w) rmem[a] = d;
        dc0 = done_cnt;
        fq.delete();
        rq.delete();
        got = 1'b0;
        hstart = 1'b0;
        hcnt = 0;
        lat = 0;
        tick();
        req = 1'b1;
        wr = w;
        addr = a;
        wdata = d;
        for (int n = 1; n <= LIM; n++) begin
            tick();
            if (n == 1) begin
                req = 1'b0;
                wr = ~w;
                addr = 13'($urandom);
                wdata = 8'($urandom);
                chk("busy_after_accept", busy, 1);
                chk("csb_after_accept", csb, 0);
                chk("si_setup", si, exp_fr[31]);
            end
            if (dbl && n == 8) req = 1'b1;
            if (dbl && n == 9) req = 1'b0;
`ifdef SRAM_HOST_HOLD_EN
            if (hold) begin
                if (hold_req) begin
                    hcnt++;
                    if (hcnt == 10) begin
                        chk("holdb_low", holdb, 0);
                        chk("sck_frozen", sck, 0);
                    end
                    if (hcnt == 20) hold_req = 1'b0;
                end else if (!hstart && rises >= 12 && !sck) begin
                    hold_req = 1'b1;
                    hstart = 1'b1;
                end
            end
`endif
            if (done) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        chk("done_seen", got, 1);
        chk("done_latency", lat, 66 * D + 1 + (hold ? 20 : 0));
        chk("rdata", rdata, exp_rd);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        repeat (3 * D + 4) tick();
        chk("frame_count", fq.size(), 1);
        if (fq.size() > 0) begin
            chk("frame_bits", fq[0], exp_fr);
            chk("pulse_count", rq[0], 32);
        end
        chk("done_pulses", done_cnt - dc0, 1);
        chk("sck_width_errs", width_err, 0);
        ref_rdata = exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [12:0] a1, a2;
        bit          got;
        int          dc0;

        for (int i = 0; i < 8192; i++) begin
            smem[i] = 8'($urandom);
            rmem[i] = smem[i];
        end

        repeat (3) tick();
        chk("rst_csb", csb, 1);
        chk("rst_sck", sck, 0);
        chk("rst_si", si, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_holdb", holdb, 1);
        rstb = 1'b1;
        tick();

        run_txn(1'b1, 13'h01A5, 8'h3C, 1'b0, 1'b0);
        smem[13'h1FFF] = 8'hC3;
        rmem[13'h1FFF] = 8'hC3;
        run_txn(1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0);
        run_txn(1'b0, 13'h01A5, 8'h00, 1'b0, 1'b0);
        run_txn(1'b1, 13'($urandom), 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            run_txn(1'($urandom), 13'($urandom), 8'($urandom),
                    1'($urandom), 1'b0);

        // Back-to-back READs with req held high.
        a1 = 13'($urandom);
        a2 = 13'($urandom);
        fq.delete();
        tick();
        req = 1'b1;
        wr = 1'b0;
        addr = a1;
        wait_done(got);
        chk("held_done1", got, 1);
        chk("held_rdata1", rdata, rmem[a1]);
        addr = a2;
        got = 1'b0;
        for (int n = 0; n < 4 * D + 10; n++) begin
            tick();
            if (busy && !done) begin
                got = 1'b1;
                break;
            end
        end
        chk("held_second_accept", got, 1);
        req = 1'b0;
        wait_done(got);
        chk("held_done2", got, 1);
        chk("held_rdata2", rdata, rmem[a2]);
        chk("held_csb_gap_ok", last_gap >= D + 2, 1);
        repeat (3 * D + 4) tick();
        chk("held_frames", fq.size(), 2);
        ref_rdata = rmem[a2];

        // Reset in the middle of a READ frame.
        dc0 = done_cnt;
        tick();
        req = 1'b1;
        wr = 1'b0;
        addr = 13'($urandom);
        tick();
        req = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 40 * D; n++) begin
            tick();
            if (rises >= 10) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_reached_10", got, 1);
        rstb = 1'b0;
        tick();
        chk("abort_csb", csb, 1);
        chk("abort_sck", sck, 0);
        chk("abort_busy", busy, 0);
        rstb = 1'b1;
        repeat (80 * D) tick();
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_rdata", rdata, 8'h00);
        ref_rdata = 8'h00;

`ifdef SRAM_HOST_HOLD_EN
        run_txn(1'b0, 13'($urandom), 8'h00, 1'b0, 1'b1);
        run_txn(1'b1, 13'($urandom), 8'($urandom), 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_spi_host.md
SRAM_SPI_HOST -- requirements
Module: sram_spi_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per sck half-period (legal values 1..255).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic on its rising edge.
REQ-003 SHALL have port rstb, input, 1 bit, meaning the reset, which is synchronous and active-low.
REQ-004 SHALL have port req, input, 1 bit, meaning the start-transaction request.
REQ-005 SHALL have port wr, input, 1 bit, meaning 1 = WRITE and 0 = READ.
REQ-006 SHALL have port addr, input, 13 bits, meaning the SRAM byte address.
REQ-007 SHALL have port wdata, input, 8 bits, meaning the write byte.
REQ-008 SHALL have port rdata, output, 8 bits, meaning the last byte read.
REQ-009 SHALL have port busy, output, 1 bit, meaning a transaction is in progress.
REQ-010 SHALL have port done, output, 1 bit, meaning a one-cycle completion pulse.
REQ-011 SHALL have port csb, output, 1 bit, meaning the SRAM chip select, active-low.
REQ-012 SHALL have port sck, output, 1 bit, meaning the serial clock.
REQ-013 SHALL have port si, output, 1 bit, meaning data driven into the SRAM si pin.
REQ-014 SHALL have port so, input, 1 bit, meaning data returned from the SRAM so pin.
REQ-015 SHALL have port holdb, output, 1 bit, meaning the SRAM hold, active-low.

Function
REQ-016 SHALL implement states IDLE, SETUP, SHIFT, GAP and DONE.
REQ-017 SHALL accept req only in IDLE; on acceptance it captures wr, addr and wdata, enters SETUP, and sets busy=1 and csb=0 from the next cycle.
REQ-018 SHALL ignore req while busy=1; changes to wr, addr and wdata after acceptance SHALL have no effect.
REQ-019 SHALL send a 32-bit frame MSB first: opcode (READ 0x03, WRITE 0x02), then {3'b000, addr}, then the data byte (wdata for WRITE, 0x00 for READ).
REQ-020 SHALL use SPI mode 0: sck idles 0; si changes only on sck falling edges or at SETUP entry; so is sampled on sck rising edges.
REQ-021 SHALL stay in SETUP for CLK_DIV cycles with sck=0 and si=frame bit 31 before leaving.
REQ-022 SHALL make SHIFT produce exactly 32 sck pulses, each high for CLK_DIV cycles and low for CLK_DIV cycles.
REQ-023 SHALL, for READ, shift the so samples from rising edges 25..32 MSB first into a holding register.
REQ-024 SHALL ignore so outside rising edges 25..32 of a READ.
REQ-025 SHALL, after the 32nd falling edge, set csb=1, enter GAP for CLK_DIV cycles, then enter DONE for one cycle with done=1, then return to IDLE.
REQ-026 SHALL update rdata from the holding register in the DONE cycle for READ only; WRITE SHALL leave rdata unchanged.
REQ-027 SHALL hold busy=1 from the cycle after acceptance through the DONE cycle.
REQ-028 SHALL assert done exactly 66*CLK_DIV+1 cycles after the accepting cycle.
REQ-029 SHALL, when req is held high continuously, start the next transaction on the first IDLE cycle, so csb is high for at least CLK_DIV+2 cycles between frames.
REQ-030 SHALL count bits with a 6-bit counter that saturates at 32 and never wraps.

Reset
REQ-031 SHALL, while rstb=0 at a rising clk edge, set state=IDLE, csb=1, sck=0, si=0, busy=0, done=0, rdata=0x00 and holdb=1.
REQ-032 SHALL, on reset mid-frame, abort the frame with csb=1 and sck=0 on the next cycle; no done pulse and no rdata update SHALL occur.

Configuration
REQ-033 SHALL, when SRAM_HOST_HOLD_EN is defined, add input hold_req (1 bit); while hold_req=1 in SHIFT with sck=0, holdb=0 and the sck/bit counters freeze, and shifting resumes where it stopped after release.
REQ-034 SHALL, when SRAM_HOST_HOLD_EN is undefined, have no hold_req port and drive holdb constant 1.

Structure
REQ-035 SHALL take opcode constants OP_READ and OP_WRITE, FRAME_BITS=32 and the state enum from shared package sram_host_pkg.
REQ-036 SHALL generate sck and its rise/fall strobes in sub-module sck_gen (divider with CLK_DIV, enable and freeze inputs).

Verification
REQ-037 SHALL cover: WRITE addr=0x01A5, wdata=0x3C, CLK_DIV=2 -> si bitstream 0x02, 0x01A5, 0x3C over 32 sck pulses; done 133 cycles after accept; rdata unchanged.
REQ-038 SHALL cover: READ addr=0x1FFF with the SRAM model returning 0xC3 -> address field 0x1FFF, rdata=0xC3 in the done cycle.
REQ-039 SHALL cover: second req pulse while busy -> ignored; exactly one frame and one done pulse.
REQ-040 SHALL cover: rstb=0 after 10 sck pulses -> csb=1 and sck=0 next cycle, no done, rdata=0x00.
REQ-041 SHALL cover: req held high for two READs -> csb high ≥ CLK_DIV+2 cycles between frames; both rdata values correct.
REQ-042 SHALL cover, with SRAM_HOST_HOLD_EN defined: hold_req=1 for 20 cycles mid-address -> holdb=0, sck frozen low, frame completes correctly with done delayed by 20 cycles.
